// File: rtl/parking_pkg.sv
// Shared types for the parking gate arbiter: FSM state encoding, travel
// direction constants and the round-robin pick helper.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT_IN  = 2'b01,
        GRANT_OUT = 2'b10,
        CLOSING   = 2'b11
    } state_e;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Entry wins when it is the only eligible side, or when the previous
    // conflict went to exit.
    function automatic logic entry_wins(input logic in_ok,
                                        input logic out_ok,
                                        input logic last_dir);
        return in_ok && (!out_ok || last_dir == DIR_OUT);
    endfunction

endpackage

// File: rtl/park_gate_timer.sv
// Gate-open timer: counts enabled cycles since the last clear and flags the
// TERMINAL-th enabled cycle. Only built when PARK_TIMEOUT_EN is defined.
module park_gate_timer #(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TERMINAL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values no matter how blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && count_q != LAST) begin
            count_q <= count_q + ONE;
        end
    end

    // The first enabled cycle sees count 0, so LAST marks the TERMINAL-th one.
    assign tc_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single-lane parking gate arbiter: grants entry/exit passages, tracks lot
// occupancy. Optional gate-open timeout is enabled by macro PARK_TIMEOUT_EN.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int OPEN_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             entry_req,
    input  logic                             exit_req,
    input  logic                             pass_done,
    output logic                             gate_open,
    output logic                             entry_gnt,
    output logic                             exit_gnt,
    output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
    output logic                             full,
    output logic                             empty
`ifdef PARK_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(CAPACITY);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    if (CAPACITY < 1 || CAPACITY > 255 || OPEN_CYCLES < 2) begin : g_bad_params
        $error("parking_gate_arbiter: CAPACITY must be 1..255 and OPEN_CYCLES >= 2");
    end

    state_e           state_q;
    logic [OCC_W-1:0] occupancy_q;
    logic [OCC_W-1:0] occupancy_d;
    logic             last_dir_q;
    logic             gate_open_q;
    logic             entry_gnt_q;
    logic             exit_gnt_q;

    logic in_ok;
    logic out_ok;
    logic pick_in;
    logic pick_out;
    logic in_grant;
    logic timer_tc;

    assign full     = (occupancy_q == OCC_MAX);
    assign empty    = (occupancy_q == '0);
    assign in_ok    = entry_req && !full;
    assign out_ok   = exit_req && !empty;
    assign pick_in  = entry_wins(in_ok, out_ok, last_dir_q);
    assign pick_out = out_ok && !pick_in;
    assign in_grant = (state_q == GRANT_IN) || (state_q == GRANT_OUT);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        occupancy_d = occupancy_q;
        if (state_q == GRANT_IN && occupancy_q != OCC_MAX) begin
            occupancy_d = occupancy_q + OCC_ONE;
        end else if (state_q == GRANT_OUT && occupancy_q != '0) begin
            occupancy_d = occupancy_q - OCC_ONE;
        end
    end

`ifdef PARK_TIMEOUT_EN
    logic timeout_err_q;

    // Held clear outside a grant, so each passage starts counting from zero.
    park_gate_timer #(
        .TERMINAL (OPEN_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!in_grant),
        .enable_i (in_grant),
        .tc_o     (timer_tc)
    );

    assign timeout_err = timeout_err_q;
`else
    assign timer_tc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            occupancy_q   <= '0;
            last_dir_q    <= DIR_OUT;
            gate_open_q   <= 1'b0;
            entry_gnt_q   <= 1'b0;
            exit_gnt_q    <= 1'b0;
`ifdef PARK_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef PARK_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_in) begin
                        state_q     <= GRANT_IN;
                        gate_open_q <= 1'b1;
                        entry_gnt_q <= 1'b1;
                    end else if (pick_out) begin
                        state_q     <= GRANT_OUT;
                        gate_open_q <= 1'b1;
                        exit_gnt_q  <= 1'b1;
                    end
                    // Round-robin memory only moves on a genuine conflict.
                    if (in_ok && out_ok) begin
                        last_dir_q <= pick_in ? DIR_IN : DIR_OUT;
                    end
                end
                GRANT_IN, GRANT_OUT: begin
                    // A completed passage beats a timeout in the same cycle.
                    if (pass_done) begin
                        state_q     <= CLOSING;
                        occupancy_q <= occupancy_d;
                        gate_open_q <= 1'b0;
                        entry_gnt_q <= 1'b0;
                        exit_gnt_q  <= 1'b0;
                    end else if (timer_tc) begin
                        state_q     <= CLOSING;
                        gate_open_q <= 1'b0;
                        entry_gnt_q <= 1'b0;
                        exit_gnt_q  <= 1'b0;
`ifdef PARK_TIMEOUT_EN
                        timeout_err_q <= 1'b1;
`endif
                    end
                end
                CLOSING: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gate_open = gate_open_q;
    assign entry_gnt = entry_gnt_q;
    assign exit_gnt  = exit_gnt_q;
    assign occupancy = occupancy_q;

endmodule
